// File: rtl/imuldiv_mul_iter_param.sv
// rtl/imuldiv_mul_iter_param.sv - iterative shift-add W x W -> 2W multiplier
// Sign handling is done on magnitudes; the product is re-signed only on the response path.
module imuldiv_mul_iter_param #(
   parameter int W          = 32,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [W-1:0]   mulreq_msg_a,
   input  logic [W-1:0]   mulreq_msg_b,
   input  logic [1:0]     mulreq_msg_fn,
   input  logic           mulreq_val,
   output logic           mulreq_rdy,
   output logic [2*W-1:0] mulresp_msg_result,
   output logic           mulresp_val,
   input  logic           mulresp_rdy,
   output logic           busy
);

   localparam int PW = 2 * W;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_q, neg_d;

   logic            req_rdy_c;
   logic            resp_val_c;
   logic            busy_c;
   logic            a_signed;
   logic            b_signed;
   logic [W-1:0]    a_mag;
   logic [W-1:0]    b_mag;
   logic            last_iter;

   function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
      return (sgn && v[W-1]) ? (~v + W'(1)) : v;
   endfunction

   // fn=11 falls through to unsigned along with fn=00
   assign a_signed  = (mulreq_msg_fn == 2'b01) || (mulreq_msg_fn == 2'b10);
   assign b_signed  = (mulreq_msg_fn == 2'b01);
   assign a_mag     = magnitude(mulreq_msg_a, a_signed);
   assign b_mag     = magnitude(mulreq_msg_b, b_signed);
   assign last_iter = (cnt_q == CW'(W - 1)) || (EARLY_TERM && (b_q[W-1:1] == '0));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      req_rdy_c  = 1'b0;
      resp_val_c = 1'b0;
      busy_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_rdy_c = 1'b1;
            if (mulreq_val) begin
               a_d     = {{W{1'b0}}, a_mag};
               b_d     = b_mag;
               acc_d   = '0;
               cnt_d   = '0;
               neg_d   = (a_signed & mulreq_msg_a[W-1]) ^ (b_signed & mulreq_msg_b[W-1]);
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            busy_c = 1'b1;
            if (b_q[0]) begin
               acc_d = acc_q + a_q;
            end
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_c     = 1'b1;
            resp_val_c = 1'b1;
            if (mulresp_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Ready is also gated by reset so a requester never sees it while reset is held
   assign mulreq_rdy         = req_rdy_c & reset_n;
   assign mulresp_val        = resp_val_c;
   assign busy               = busy_c;
   assign mulresp_msg_result = neg_q ? (~acc_q + PW'(1)) : acc_q;

endmodule

// File: tb/tb_imuldiv_mul_iter_param.sv
// tb/tb_imuldiv_mul_iter_param.sv - directed and scoreboard bench for imuldiv_mul_iter_param
module tb_imuldiv_mul_iter_param;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] a, b;
   logic [1:0]  fn;
   logic        val, rdy32;
   logic        rq32, rv32, busy32;
   logic [63:0] res32;

   logic [7:0]  a8, b8;
   logic [1:0]  fn8;
   logic        val8, rr8;
   logic        rq_e, rv_e, busy_e, rq_f, rv_f, busy_f;
   logic [15:0] res_e, res_f;

   int total = 0;
   int bad   = 0;

   imuldiv_mul_iter_param #(.W(32), .EARLY_TERM(1'b1)) dut32 (
      .clk(clk), .reset_n(reset_n),
      .mulreq_msg_a(a), .mulreq_msg_b(b), .mulreq_msg_fn(fn),
      .mulreq_val(val), .mulreq_rdy(rq32),
      .mulresp_msg_result(res32), .mulresp_val(rv32), .mulresp_rdy(rdy32),
      .busy(busy32)
   );

   imuldiv_mul_iter_param #(.W(8), .EARLY_TERM(1'b1)) dut8e (
      .clk(clk), .reset_n(reset_n),
      .mulreq_msg_a(a8), .mulreq_msg_b(b8), .mulreq_msg_fn(fn8),
      .mulreq_val(val8), .mulreq_rdy(rq_e),
      .mulresp_msg_result(res_e), .mulresp_val(rv_e), .mulresp_rdy(rr8),
      .busy(busy_e)
   );

   imuldiv_mul_iter_param #(.W(8), .EARLY_TERM(1'b0)) dut8f (
      .clk(clk), .reset_n(reset_n),
      .mulreq_msg_a(a8), .mulreq_msg_b(b8), .mulreq_msg_fn(fn8),
      .mulreq_val(val8), .mulreq_rdy(rq_f),
      .mulresp_msg_result(res_f), .mulresp_val(rv_f), .mulresp_rdy(rr8),
      .busy(busy_f)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Entered #1 after a rising edge with dut32 in IDLE; returns in the first DONE cycle.
   task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] ifn,
                       output logic [63:0] r, output int lat);
      a = ia; b = ib; fn = ifn; val = 1'b1;
      check("req_rdy", {63'b0, rq32}, 64'd1);
      @(posedge clk); #1;
      val = 1'b0;
      lat = 1;
      while (!rv32 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("resp_val", {63'b0, rv32}, 64'd1);
      r = res32;
   endtask

   task automatic run32(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [1:0] ifn, input logic [63:0] exp, input int explat);
      logic [63:0] r;
      int          lat;
      op32(ia, ib, ifn, r, lat);
      check(tag, r, exp);
      check({tag, "_lat"}, 64'(lat), 64'(explat));
      @(posedge clk); #1;
   endtask

   task automatic run8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [1:0] ifn, input logic [15:0] exp, input int late, input int latf);
      int          c, le, lf;
      logic [15:0] re, rf;
      le = 0; lf = 0; re = '0; rf = '0;
      a8 = ia; b8 = ib; fn8 = ifn; val8 = 1'b1;
      @(posedge clk); #1;
      val8 = 1'b0;
      c = 1;
      while ((le == 0 || lf == 0) && c < 100) begin
         if (rv_e && le == 0) begin le = c; re = res_e; end
         if (rv_f && lf == 0) begin lf = c; rf = res_f; end
         if (le == 0 || lf == 0) begin
            @(posedge clk); #1;
            c++;
         end
      end
      check({tag, "_et"}, 64'(re), 64'(exp));
      check({tag, "_fix"}, 64'(rf), 64'(exp));
      check({tag, "_et_lat"}, 64'(le), 64'(late));
      check({tag, "_fix_lat"}, 64'(lf), 64'(latf));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] r, ea, eb;
      logic [31:0] mb;
      int          lat, n;

      a = '0; b = '0; fn = '0; val = 1'b0; rdy32 = 1'b1;
      a8 = '0; b8 = '0; fn8 = '0; val8 = 1'b0; rr8 = 1'b1;

      #12;
      check("rst_req_rdy", {63'b0, rq32}, 64'd0);
      check("rst_resp_val", {63'b0, rv32}, 64'd0);
      check("rst_busy", {63'b0, busy32}, 64'd0);
      check("rst_result", res32, 64'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("idle_req_rdy", {63'b0, rq32}, 64'd1);
      check("idle_req_rdy8", {62'b0, rq_e, rq_f}, 64'd3);

      run32("ss_7x-3", 32'd7, 32'hFFFF_FFFD, 2'b01, 64'hFFFF_FFFF_FFFF_FFEB, 3);
      run32("uu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001, 33);
      run32("fn11_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 64'hFFFF_FFFE_0000_0001, 33);
      run32("ss_minint", 32'h8000_0000, 32'h8000_0000, 2'b01, 64'h4000_0000_0000_0000, 33);
      run32("su_neg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFF_0000_0001, 33);
      run32("b_zero", 32'h8001_2345, 32'd0, 2'b01, 64'd0, 2);

      rdy32 = 1'b0;
      op32(32'd7, 32'hFFFF_FFFD, 2'b01, r, lat);
      check("bp_result", r, 64'hFFFF_FFFF_FFFF_FFEB);
      check("bp_lat", 64'(lat), 64'd3);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("bp_hold_result", res32, 64'hFFFF_FFFF_FFFF_FFEB);
         check("bp_hold_req_rdy", {63'b0, rq32}, 64'd0);
         check("bp_hold_busy", {63'b0, busy32}, 64'd1);
      end
      rdy32 = 1'b1;
      @(posedge clk); #1;
      run32("bp_next", 32'd6, 32'd9, 2'b00, 64'd54, 5);

      a = 32'h0000_FFFF; b = 32'hFFFF_0000; fn = 2'b00; val = 1'b1;
      @(posedge clk); #1;
      val = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      check("mid_calc_busy", {63'b0, busy32}, 64'd1);
      reset_n = 1'b0;
      #1;
      check("abort_resp_val", {63'b0, rv32}, 64'd0);
      check("abort_busy", {63'b0, busy32}, 64'd0);
      check("abort_req_rdy", {63'b0, rq32}, 64'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_abort_resp_val", {63'b0, rv32}, 64'd0);
      run32("post_abort_3x5", 32'd3, 32'd5, 2'b00, 64'd15, 4);

      run8("w8_ss", 8'h80, 8'h7F, 2'b01, 16'hC080, 8, 9);
      run8("w8_b1", 8'h05, 8'h01, 2'b00, 16'h0005, 2, 9);
      run8("w8_su", 8'hFF, 8'hFF, 2'b10, 16'hFF01, 9, 9);

      for (int i = 0; i < 24; i++) begin
         logic [31:0] ra, rb;
         logic [1:0]  rf;
         rf = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if (i % 6 == 5) rb = 32'hFFFF_FFFF - rb;
         ea = (rf == 2'b01 || rf == 2'b10) ? {{32{ra[31]}}, ra} : {32'b0, ra};
         eb = (rf == 2'b01) ? {{32{rb[31]}}, rb} : {32'b0, rb};
         mb = (rf == 2'b01 && rb[31]) ? (32'd0 - rb) : rb;
         n = 1;
         for (int k = 0; k < 32; k++) if (mb[k]) n = k + 1;
         run32("rand", ra, rb, rf, ea * eb, n + 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
